// File: rtl/rad4_booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, valid/ready on both sides,
// per-operation signed/unsigned mode selected by widening both operands by two bits.
module rad4_booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     mltplr_i,
    input  logic [WIDTH-1:0]     mltplcnd_i,
    input  logic                 signed_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   prdct_o
);

    localparam int N     = WIDTH / 2 + 1;
    localparam int AW    = 2 * WIDTH + 4;
    localparam int QW    = WIDTH + 3;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     in_ready_q, in_ready_d;
    logic [2*WIDTH-1:0]       prdct_q, prdct_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic signed [AW-1:0]     mcand_q, mcand_d;
    logic [QW-1:0]            mplr_q, mplr_d;
    logic signed [AW-1:0]     acc_sum;
    logic                     cnd_sx, plr_sx;

    // Booth recoding of one digit {q[2i+1], q[2i], q[2i-1]} against the pre-weighted multiplicand.
    function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] dig,
                                                      input logic signed [AW-1:0] m);
        case (dig)
            3'b001, 3'b010: return m;
            3'b011:         return m <<< 1;
            3'b100:         return -(m <<< 1);
            3'b101, 3'b110: return -m;
            default:        return '0;
        endcase
    endfunction

    assign cnd_sx  = signed_i & mltplcnd_i[WIDTH-1];
    assign plr_sx  = signed_i & mltplr_i[WIDTH-1];
    assign acc_sum = acc_q + booth_pp(mplr_q[2:0], mcand_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prdct_d  = prdct_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    mcand_d = {{(AW - WIDTH){cnd_sx}}, mltplcnd_i};
                    mplr_d  = {{2{plr_sx}}, mltplr_i, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Multiplier shifts down and multiplicand up, so digit i always sits at bits [2:0].
                acc_d   = acc_sum;
                mplr_d  = {2'b00, mplr_q[QW-1:2]};
                mcand_d = mcand_q <<< 2;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    prdct_d = acc_sum[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prdct_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prdct_q    <= prdct_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        acc_q   <= acc_d;
        mcand_q <= mcand_d;
        mplr_q  <= mplr_d;
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == DONE);
    assign prdct_o     = prdct_q;

endmodule

// File: tb/tb_rad4_booth_mul_seq.sv
// Bench for rad4_booth_mul_seq: directed 8-bit corners, backpressure and reset-abort,
// then randomized 16-bit traffic checked against an integer-arithmetic product model.
module tb_rad4_booth_mul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8;
    logic [7:0]  mplr8, mcnd8;
    logic [15:0] prdct8;

    logic        in_valid16, in_ready16, sgn16, out_valid16, out_ready16;
    logic [15:0] mplr16, mcnd16;
    logic [31:0] prdct16;

    int errors = 0;
    int checks = 0;

    rad4_booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .mltplr_i(mplr8), .mltplcnd_i(mcnd8), .signed_i(sgn8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8), .prdct_o(prdct8)
    );

    rad4_booth_mul_seq #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid16), .in_ready_o(in_ready16),
        .mltplr_i(mplr16), .mltplcnd_i(mcnd16), .signed_i(sgn16),
        .out_valid_o(out_valid16), .out_ready_i(out_ready16), .prdct_o(prdct16)
    );

    // Exact product of two w-bit operands interpreted per mode.
    function automatic longint model(input longint a, input longint b, input logic s, input int w);
        if (s && a[w-1]) a = a - (longint'(1) << w);
        if (s && b[w-1]) b = b - (longint'(1) << w);
        return a * b;
    endfunction

    // Issue one 8-bit operation; returns at the negedge where out_valid is seen (or timeout).
    // lat counts rising edges with the accept edge as edge 1.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] p, output int lat);
        int guard = 0;
        while (!in_ready8 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        mplr8 = a; mcnd8 = b; sgn8 = s; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = prdct8;
    endtask

    task automatic finish8(output logic rdy_after, output logic vld_after);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        rdy_after = in_ready8;
        vld_after = out_valid8;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid8); end
        checks++; if (prdct8 !== 16'h0000) begin errors++; $display("FAIL rst_prdct got=%h exp=0000", prdct8); end
        checks++; if (in_ready16 !== 1'b0) begin errors++; $display("FAIL rst_in_ready16 got=%b exp=0", in_ready16); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready8); end
        checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready16 got=%b exp=1", in_ready16); end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    task automatic test_directed;
        vec_t vecs[6];
        logic [15:0] p;
        int lat;
        logic rdy, vld;
        vecs[0] = '{8'hFB, 8'h08, 1'b1, 16'hFFD8};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[4] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
            checks++; if (lat !== 6) begin errors++; $display("FAIL latency[%0d] got=%0d exp=6", i, lat); end
            checks++; if (p !== vecs[i].p) begin errors++; $display("FAIL prdct[%0d] got=%h exp=%h", i, p, vecs[i].p); end
            finish8(rdy, vld);
            checks++; if (rdy !== 1'b1 || vld !== 1'b0) begin
                errors++; $display("FAIL handshake[%0d] got rdy=%b vld=%b exp rdy=1 vld=0", i, rdy, vld);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] a, b;
        logic s;
        logic [15:0] p, exp;
        longint t;
        int lat;
        logic rdy, vld;
        a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
        t = model(longint'(a), longint'(b), s, 8);
        exp = t[15:0];
        run8(a, b, s, p, lat);
        checks++; if (p !== exp) begin errors++; $display("FAIL bp_prdct got=%h exp=%h", p, exp); end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid8 !== 1'b1 || prdct8 !== exp || in_ready8 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got vld=%b p=%h rdy=%b exp vld=1 p=%h rdy=0",
                         c, out_valid8, prdct8, in_ready8, exp);
            end
            in_valid8 = 1'($urandom); mplr8 = 8'($urandom); mcnd8 = 8'($urandom); sgn8 = 1'($urandom);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        finish8(rdy, vld);
        checks++; if (rdy !== 1'b1 || vld !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", rdy, vld);
        end
    endtask

    task automatic test_reset_mid_calc;
        logic seen_vld = 1'b0;
        logic bad_p = 1'b0;
        logic [15:0] p;
        int lat;
        logic rdy, vld;
        mplr8 = 8'h5A; mcnd8 = 8'hC3; sgn8 = 1'b1; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid8 !== 1'b0) seen_vld = 1'b1;
            if (prdct8 !== 16'h0000) bad_p = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_vld !== 1'b0) begin errors++; $display("FAIL abort_no_valid got=%b exp=0", seen_vld); end
        checks++; if (bad_p !== 1'b0) begin errors++; $display("FAIL abort_prdct_zero got=%b exp=0", bad_p); end
        run8(8'd3, 8'd7, 1'b1, p, lat);
        checks++; if (p !== 16'h0015 || lat !== 6) begin
            errors++; $display("FAIL after_abort got p=%h lat=%0d exp p=0015 lat=6", p, lat);
        end
        finish8(rdy, vld);
    endtask

    task automatic test_back_to_back_w16;
        logic [31:0] q[$];
        logic [31:0] exp;
        longint t;
        int accepted = 0;
        int results = 0;
        int cyc = 0;
        while (results < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid16  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            mplr16      = 16'($urandom);
            mcnd16      = 16'($urandom);
            sgn16       = 1'($urandom);
            out_ready16 = ($urandom_range(0, 9) < 7);
            if (in_valid16 && in_ready16) begin
                t = model(longint'(mplr16), longint'(mcnd16), sgn16, 16);
                q.push_back(t[31:0]);
                accepted++;
            end
            if (out_valid16 && out_ready16) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected_result got=%h exp=none", prdct16);
                end else begin
                    exp = q.pop_front();
                    if (prdct16 !== exp) begin
                        errors++; $display("FAIL rand_prdct[%0d] got=%h exp=%h", results, prdct16, exp);
                    end
                end
                results++;
            end
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b0;
        checks++;
        if (results != 1000 || accepted != 1000) begin
            errors++; $display("FAIL rand_count got results=%0d accepts=%0d exp 1000/1000", results, accepted);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; mplr8 = '0; mcnd8 = '0; sgn8 = 1'b0; out_ready8 = 1'b0;
        in_valid16 = 1'b0; mplr16 = '0; mcnd16 = '0; sgn16 = 1'b0; out_ready16 = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back_w16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
